// File: rtl/fir_stream_sequencer.sv
// +--------------------------------------------------------------------------+
// | fir_stream_sequencer: run controller feeding a FIR datapath, flushing it |
// | with zero samples and buffering valid results in an output FIFO. Rev 1.0 |
// +--------------------------------------------------------------------------+
`default_nettype none

module fir_stream_sequencer #(
    parameter int NTAPS     = 8,
    parameter int IW        = 12,
    parameter int OW        = 31,
    parameter int OUT_DEPTH = 8
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_start,
    input  logic          i_abort,
    input  logic [3:0]    i_ntaps,
    input  logic [15:0]   i_in_len,
    input  logic [IW-1:0] s_sample,
    input  logic          s_valid,
    output logic          s_ready,
    output logic          fir_reset,
    output logic          fir_ce,
    output logic [IW-1:0] fir_sample,
    input  logic [OW-1:0] fir_result,
    output logic [OW-1:0] m_result,
    output logic          m_valid,
    input  logic          m_ready,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_err,
    output logic [15:0]   o_out_cnt
);

    localparam int AW = $clog2(OUT_DEPTH);
    localparam logic [AW:0] DEPTH = (AW+1)'(OUT_DEPTH);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_FEED  = 3'd2;
    localparam logic [2:0] S_FLUSH = 3'd3;
    localparam logic [2:0] S_LAST  = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [15:0]   n_q, n_d;
    logic [15:0]   in_len_q, in_len_d;
    logic [15:0]   skip_q, skip_d;
    logic [15:0]   total_q, total_d;
    logic          cap_q, cap_d;
    logic [15:0]   out_cnt_q, out_cnt_d;
    logic          err_q, err_d;
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   cnt_q;
    logic [OW-1:0] mem_q [OUT_DEPTH];

    logic          cfg_ok;
    logic          space;
    logic          ce;
    logic          push;
    logic          pop;
    logic [15:0]   n_next;

    assign cfg_ok = (i_ntaps != 4'd0) && (32'(i_ntaps) <= NTAPS) && (i_in_len != 16'd0);
    // A capture already registered for next cycle claims one free entry.
    assign space  = (DEPTH - cnt_q) > {{AW{1'b0}}, cap_q};
    assign ce     = !i_abort && space
                    && (((state_q == S_FEED) && s_valid) || (state_q == S_FLUSH));
    assign push   = cap_q && !i_abort;
    assign pop    = m_ready && (cnt_q != '0) && !i_abort;
    assign n_next = n_q + 16'd1;

    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        in_len_d  = in_len_q;
        skip_d    = skip_q;
        total_d   = total_q;
        err_d     = err_q;
        cap_d     = ce && (n_next > skip_q);
        out_cnt_d = (state_q == S_CLEAR) ? 16'd0 : out_cnt_q + {15'd0, push};
        if (i_abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (i_start) begin
                        if (cfg_ok) begin
                            state_d  = S_CLEAR;
                            err_d    = 1'b0;
                            in_len_d = i_in_len;
                            skip_d   = {11'd0, i_ntaps, 1'b0};
                            total_d  = i_in_len + 16'(i_ntaps) * 16'd3 - 16'd1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                S_CLEAR: begin
                    n_d     = 16'd0;
                    state_d = S_FEED;
                end
                S_FEED: begin
                    if (ce) begin
                        n_d = n_next;
                        if (n_next == in_len_q) begin
                            state_d = (in_len_q == total_q) ? S_LAST : S_FLUSH;
                        end
                    end
                end
                S_FLUSH: begin
                    if (ce) begin
                        n_d = n_next;
                        if (n_next == total_q) begin
                            state_d = S_LAST;
                        end
                    end
                end
                S_LAST:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q   <= S_IDLE;
            n_q       <= 16'd0;
            in_len_q  <= 16'd0;
            skip_q    <= 16'd0;
            total_q   <= 16'd0;
            cap_q     <= 1'b0;
            out_cnt_q <= 16'd0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            in_len_q  <= in_len_d;
            skip_q    <= skip_d;
            total_q   <= total_d;
            cap_q     <= cap_d;
            out_cnt_q <= out_cnt_d;
            err_q     <= err_d;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (i_abort) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) mem_q[wr_ptr_q] <= fir_result;
    end

    assign fir_ce     = ce;
    assign s_ready    = ce && (state_q == S_FEED);
    assign fir_sample = (state_q == S_FEED) ? s_sample : '0;
    assign fir_reset  = i_reset || (state_q == S_CLEAR) || (i_abort && (state_q != S_IDLE));
    assign m_result   = mem_q[rd_ptr_q];
    assign m_valid    = (cnt_q != '0);
    assign o_busy     = (state_q != S_IDLE);
    assign o_done     = (state_q == S_LAST) && !i_abort;
    assign o_err      = err_q;
    assign o_out_cnt  = out_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_fir_stream_sequencer.sv
// +--------------------------------------------------------------------------+
// | tb_fir_stream_sequencer: scoreboard bench with a tagging FIR stand-in.   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_fir_stream_sequencer;

    localparam int IW = 12;
    localparam int OW = 31;

    logic          clk = 1'b0;
    logic          i_reset, i_start, i_abort;
    logic [3:0]    i_ntaps;
    logic [15:0]   i_in_len;
    logic [IW-1:0] s_sample;
    logic          s_valid, s_ready;
    logic          fir_reset, fir_ce;
    logic [IW-1:0] fir_sample;
    logic [OW-1:0] fir_result;
    logic [OW-1:0] m_result;
    logic          m_valid, m_ready;
    logic          o_busy, o_done, o_err;
    logic [15:0]   o_out_cnt;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int ce_total = 0;
    int done_total = 0;
    int last_ce_cyc = 0;
    int done_cyc = 0;
    logic [15:0]   fcnt;
    logic [OW-1:0] exp_q [$];

    always #5 clk = ~clk;

    fir_stream_sequencer dut (
        .i_clk(clk), .i_reset(i_reset), .i_start(i_start), .i_abort(i_abort),
        .i_ntaps(i_ntaps), .i_in_len(i_in_len),
        .s_sample(s_sample), .s_valid(s_valid), .s_ready(s_ready),
        .fir_reset(fir_reset), .fir_ce(fir_ce), .fir_sample(fir_sample),
        .fir_result(fir_result),
        .m_result(m_result), .m_valid(m_valid), .m_ready(m_ready),
        .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .o_out_cnt(o_out_cnt)
    );

    // FIR stand-in: each result is tagged with its pulse index and sample.
    always @(posedge clk) begin
        if (fir_reset) begin
            fcnt       <= 16'd0;
            fir_result <= '0;
        end else if (fir_ce) begin
            fcnt       <= fcnt + 16'd1;
            fir_result <= {3'b000, 16'(fcnt + 16'd1), fir_sample};
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (fir_ce) begin
            ce_total    <= ce_total + 1;
            last_ce_cyc <= cyc;
        end
        if (o_done) begin
            done_total <= done_total + 1;
            done_cyc   <= cyc;
        end
    end

    task automatic check(input string name, input longint act, input longint req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid && m_ready && !i_reset && !i_abort) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", longint'(m_result), -1);
            end else begin
                check("result", longint'(m_result), longint'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input int nt, input int len, input int base, input bit expect_res);
        int skip, total;
        logic [IW-1:0] smp;
        i_ntaps  = 4'(nt);
        i_in_len = 16'(len);
        i_start  = 1'b1;
        tick();
        i_start  = 1'b0;
        if (expect_res) begin
            skip  = 2 * nt;
            total = len + 3 * nt - 1;
            for (int k = skip + 1; k <= total; k++) begin
                smp = (k <= len) ? IW'(base + k - 1) : '0;
                exp_q.push_back({3'b000, 16'(k), smp});
            end
        end
    endtask

    task automatic feed(input int len, input int base, input bit gap);
        int w;
        for (int i = 0; i < len; i++) begin
            s_valid  = 1'b1;
            s_sample = IW'(base + i);
            w = 0;
            forever begin
                @(negedge clk);
                if (s_ready) break;
                w++;
                if (w > 300) break;
            end
            if (w > 300) begin
                check("feed_timeout", 0, 1);
                s_valid = 1'b0;
                return;
            end
            tick();
            if (gap) begin
                s_valid = 1'b0;
                tick();
            end
        end
        s_valid = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int w = 0;
        forever begin
            @(negedge clk);
            if (!o_busy) break;
            w++;
            if (w > limit) break;
        end
        if (w > limit) check("idle_timeout", 0, 1);
        tick();
    endtask

    task automatic drain(input int limit);
        int w = 0;
        while (exp_q.size() != 0 && w <= limit) begin
            tick();
            w++;
        end
        check("drain_remaining", exp_q.size(), 0);
    endtask

    task automatic full_run(input int nt, input int len, input int base, input bit gap);
        int ce0, d0;
        ce0 = ce_total;
        d0  = done_total;
        start_run(nt, len, base, 1'b1);
        check("err_after_legal_start", o_err, 0);
        feed(len, base, gap);
        wait_idle(200);
        check("ce_pulses", ce_total - ce0, len + 3 * nt - 1);
        check("done_pulses", done_total - d0, 1);
        check("done_after_last_ce", done_cyc - last_ce_cyc, 1);
        check("out_cnt", o_out_cnt, len + nt - 1);
        drain(100);
    endtask

    initial begin
        int ce0, d0;
        i_reset = 1'b1; i_start = 1'b0; i_abort = 1'b0;
        i_ntaps = 4'd0; i_in_len = 16'd0;
        s_sample = '0; s_valid = 1'b0; m_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);
        check("rst_err", o_err, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_fir_reset", fir_reset, 1);
        check("rst_fir_ce", fir_ce, 0);
        check("rst_out_cnt", o_out_cnt, 0);
        tick();
        i_reset = 1'b0;
        tick();

        // basic run, then the same run with a 1010 valid pattern
        full_run(3, 4, 100, 1'b0);
        full_run(3, 4, 100, 1'b1);

        // backpressure: FIFO fills, fir_ce stalls, then drains in order
        m_ready = 1'b0;
        ce0 = ce_total;
        d0  = done_total;
        start_run(8, 20, 200, 1'b1);
        feed(20, 200, 1'b0);
        repeat (30) tick();
        check("stall_ce", ce_total - ce0, 24);
        check("stall_out_cnt", o_out_cnt, 8);
        check("stall_m_valid", m_valid, 1);
        check("stall_busy", o_busy, 1);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        repeat (5) tick();
        check("busy_start_ignored_ce", ce_total - ce0, 24);
        check("busy_start_ignored_cnt", o_out_cnt, 8);
        m_ready = 1'b1;
        wait_idle(300);
        check("bp_ce", ce_total - ce0, 43);
        check("bp_out_cnt", o_out_cnt, 27);
        check("bp_done", done_total - d0, 1);
        drain(100);

        // abort where pulse 5 would occur
        ce0 = ce_total;
        d0  = done_total;
        start_run(3, 4, 100, 1'b0);
        feed(4, 100, 1'b0);
        i_abort = 1'b1;
        @(negedge clk);
        check("abort_fir_reset", fir_reset, 1);
        check("abort_fir_ce", fir_ce, 0);
        check("abort_done", o_done, 0);
        tick();
        i_abort = 1'b0;
        check("abort_busy", o_busy, 0);
        check("abort_m_valid", m_valid, 0);
        tick();
        check("abort_ce", ce_total - ce0, 4);
        check("abort_no_done", done_total - d0, 0);

        // illegal configurations, then a legal start clears o_err
        start_run(0, 4, 0, 1'b0);
        check("err_ntaps0", o_err, 1);
        check("busy_ntaps0", o_busy, 0);
        start_run(3, 0, 0, 1'b0);
        check("err_len0", o_err, 1);
        check("busy_len0", o_busy, 0);
        start_run(9, 4, 0, 1'b0);
        check("err_ntaps9", o_err, 1);
        check("busy_ntaps9", o_busy, 0);
        full_run(3, 4, 300, 1'b0);

        // asynchronous reset during FLUSH
        m_ready = 1'b0;
        d0 = done_total;
        start_run(3, 4, 100, 1'b0);
        feed(4, 100, 1'b0);
        tick();
        check("pre_reset_busy", o_busy, 1);
        #2 i_reset = 1'b1;
        #1;
        check("arst_busy", o_busy, 0);
        check("arst_fir_reset", fir_reset, 1);
        check("arst_fir_ce", fir_ce, 0);
        check("arst_s_ready", s_ready, 0);
        check("arst_m_valid", m_valid, 0);
        check("arst_out_cnt", o_out_cnt, 0);
        check("arst_done", o_done, 0);
        tick();
        i_reset = 1'b0;
        m_ready = 1'b1;
        repeat (3) tick();
        check("arst_no_done", done_total - d0, 0);
        check("final_queue", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
